debounced_ruler: RTL and testbench



---
 rtl/debounced_ruler.sv | 99 +++++++++
 tb/tb_debounced_ruler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_ruler.sv
// debounced_ruler: sync + debounce of strobe/direction contacts,
// each clean strobe rise moves a saturating one-hot ruler marker.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    async active-low reset
//   stb_i    raw strobe contact (async, bouncy)
//   dir_i    raw direction contact, 1 = toward MSB
//   ruler_o  one-hot marker position
//   stb_db_o debounced strobe level
//   dir_db_o debounced direction level
module debounced_ruler #(
  parameter int RULER_WIDTH     = 8,
  parameter int DEBOUNCER_DELAY = 50_000_000 / 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stb_i,
  input  logic                   dir_i,
  output logic [RULER_WIDTH-1:0] ruler_o,
  output logic                   stb_db_o,
  output logic                   dir_db_o
);

  localparam int CW = $clog2(DEBOUNCER_DELAY + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCER_DELAY - 1);
  localparam logic [RULER_WIDTH-1:0] RULER_RST = RULER_WIDTH'(1);

  // channel 0 = strobe, channel 1 = direction
  logic [1:0]    raw;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    db_q;
  logic [1:0]    db_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic                   stb_prev_q;
  logic                   step;
  logic [RULER_WIDTH-1:0] ruler_q;
  logic [RULER_WIDTH-1:0] ruler_d;

  assign raw = {dir_i, stb_i};

  // Any cycle where the synced input matches the output restarts
  // the count, so only an unbroken run of DELAY cycles commits.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign step = db_q[0] & ~stb_prev_q;

  // Saturating move: the edge bit blocks the shift, keeping one-hot.
  always_comb begin
    ruler_d = ruler_q;
    if (step) begin
      if (db_q[1]) begin
        if (!ruler_q[RULER_WIDTH-1]) ruler_d = ruler_q << 1;
      end else begin
        if (!ruler_q[0]) ruler_d = ruler_q >> 1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      stb_prev_q <= 1'b0;
      ruler_q    <= RULER_RST;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      stb_prev_q <= db_q[0];
      ruler_q    <= ruler_d;
    end
  end

  assign ruler_o  = ruler_q;
  assign stb_db_o = db_q[0];
  assign dir_db_o = db_q[1];

endmodule

// File: tb/tb_debounced_ruler.sv
// tb_debounced_ruler: scoreboard bench for debounced_ruler,
// DEBOUNCER_DELAY = 4, RULER_WIDTH = 8.
module tb_debounced_ruler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stb;
  logic       dir;
  logic [7:0] ruler;
  logic       stb_db;
  logic       dir_db;

  debounced_ruler #(
    .RULER_WIDTH(8),
    .DEBOUNCER_DELAY(4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .stb_i   (stb),
    .dir_i   (dir),
    .ruler_o (ruler),
    .stb_db_o(stb_db),
    .dir_db_o(dir_db)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    int         edge_no;
    logic [7:0] ruler;
    logic       stb_db;
    logic       dir_db;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   pass  = 0;

  logic [7:0] e_ruler;
  logic       e_stb;
  logic       e_dir;

  logic [7:0] up_tbl [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                             8'h40, 8'h80, 8'h80, 8'h80};
  logic [7:0] dn_tbl [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04,
                             8'h02, 8'h01, 8'h01};

  task automatic push(int e, string nm);
    exp_t x;
    x.edge_no = e;
    x.ruler   = e_ruler;
    x.stb_db  = e_stb;
    x.dir_db  = e_dir;
    x.name    = nm;
    sbq.push_back(x);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every visible output change must match the head of
  // the scoreboard, including the edge on which it happened.
  logic [9:0] prev = '0;
  always @(negedge clk) begin
    logic [9:0] cur;
    exp_t       x;
    cur = {ruler, stb_db, dir_db};
    if (!rst_n) begin
      prev = cur;
    end else if (cur !== prev) begin
      prev = cur;
      total++;
      if (sbq.size() == 0) begin
        $display("FAIL unexpected_change: edge %0d ruler %b stb_db %b dir_db %b",
                 edge_n, ruler, stb_db, dir_db);
      end else begin
        x = sbq.pop_front();
        if (x.edge_no == edge_n && x.ruler === ruler &&
            x.stb_db === stb_db && x.dir_db === dir_db) begin
          pass++;
        end else begin
          $display("FAIL %s: edge %0d ruler %b stb_db %b dir_db %b, expected edge %0d ruler %b stb_db %b dir_db %b",
                   x.name, edge_n, ruler, stb_db, dir_db,
                   x.edge_no, x.ruler, x.stb_db, x.dir_db);
        end
      end
    end
  end

  task automatic set_dir(logic v);
    int k;
    @(negedge clk);
    dir = v;
    k = edge_n + 1;
    if (v != e_dir) begin
      e_dir = v;
      push(k + 5, "dir_db");
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic stb_rise(logic [7:0] exp_r);
    int k;
    @(negedge clk);
    stb = 1'b1;
    k = edge_n + 1;
    e_stb = 1'b1;
    push(k + 5, "stb_db_rise");
    if (exp_r != e_ruler) begin
      e_ruler = exp_r;
      push(k + 6, "ruler_step");
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic stb_fall();
    int k;
    @(negedge clk);
    stb = 1'b0;
    k = edge_n + 1;
    e_stb = 1'b0;
    push(k + 5, "stb_db_fall");
    repeat (8) @(negedge clk);
  endtask

  task automatic strobe(logic [7:0] exp_r);
    stb_rise(exp_r);
    stb_fall();
  endtask

  // Assert reset now, check async effect, release with given inputs.
  task automatic pulse_reset(logic sh, logic dh);
    int k;
    rst_n = 1'b0;
    #1;
    chk("rst_ruler", 32'(ruler), 32'h01);
    chk("rst_stb_db", 32'(stb_db), 32'h0);
    chk("rst_dir_db", 32'(dir_db), 32'h0);
    stb = sh;
    dir = dh;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = edge_n + 1;
    e_ruler = 8'h01;
    e_stb = sh;
    e_dir = dh;
    if (sh || dh) push(k + 5, "post_rst_db");
    if (sh && dh) begin
      e_ruler = 8'h02;
      push(k + 6, "post_rst_step");
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    rst_n = 1'b1;
    stb = 1'b0;
    dir = 1'b0;
    e_ruler = 8'h01;
    e_stb = 1'b0;
    e_dir = 1'b0;

    // reset with random inputs, checked before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_ruler", 32'(ruler), 32'h01);
    chk("reset_async_stb", 32'(stb_db), 32'h0);
    chk("reset_async_dir", 32'(dir_db), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stb = 1'($urandom);
      dir = 1'($urandom);
      #1;
      chk("reset_hold_ruler", 32'(ruler), 32'h01);
      chk("reset_hold_db", 32'({stb_db, dir_db}), 32'h0);
    end
    @(negedge clk);
    stb = 1'b0;
    dir = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // latency, then hold high
    set_dir(1'b1);
    stb_rise(8'h02);
    repeat (20) @(negedge clk);
    chk("hold_ruler", 32'(ruler), 32'h02);
    chk("hold_stb_db", 32'(stb_db), 32'h1);
    stb_fall();

    // 3-cycle glitch is rejected
    @(negedge clk);
    stb = 1'b1;
    repeat (3) @(negedge clk);
    stb = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_stb_db", 32'(stb_db), 32'h0);
    chk("glitch_ruler", 32'(ruler), 32'h02);

    // bounce 1,0,1,1,1,1,1: timing from the last rise
    @(negedge clk);
    stb = 1'b1;
    k0 = edge_n + 1;
    e_stb = 1'b1;
    push(k0 + 7, "bounce_stb_db");
    e_ruler = 8'h04;
    push(k0 + 8, "bounce_step");
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    stb = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_ruler", 32'(ruler), 32'h04);
    stb_fall();

    // saturation at MSB from reset
    @(negedge clk);
    pulse_reset(1'b0, 1'b0);
    set_dir(1'b1);
    for (int i = 0; i < 9; i++) strobe(up_tbl[i]);
    chk("msb_sat", 32'(ruler), 32'h80);

    // saturation at LSB
    set_dir(1'b0);
    for (int i = 0; i < 8; i++) strobe(dn_tbl[i]);
    chk("lsb_sat", 32'(ruler), 32'h01);

    // reset mid-operation
    set_dir(1'b1);
    for (int i = 0; i < 4; i++) strobe(up_tbl[i]);
    chk("pre_rst_ruler", 32'(ruler), 32'h10);
    @(negedge clk);
    stb = 1'b1;
    repeat (4) @(negedge clk);
    pulse_reset(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("interrupted_no_step", 32'(ruler), 32'h01);

    @(negedge clk);
    stb = 1'b1;
    repeat (4) @(negedge clk);
    pulse_reset(1'b1, 1'b1);
    chk("held_through_rst", 32'(ruler), 32'h02);
    stb_fall();

    repeat (20) @(negedge clk);
    while (sbq.size() != 0) begin
      exp_t x;
      x = sbq.pop_front();
      total++;
      $display("FAIL %s: no change seen, expected at edge %0d ruler %b",
               x.name, x.edge_no, x.ruler);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
